// File: rtl/uart_rx_fsm.sv
// ============================================================================
// uart_rx_fsm -- UART receiver for 8N1 frames (8E1 with UART_RX_PARITY_EN)
// ============================================================================
// Purpose
//   Recovers serial frames (start bit, 8 data bits LSB first, optional even
//   parity bit, stop bit) from an asynchronous serial line. The line is
//   synchronised first. Each bit is then sampled once at its midpoint, timed
//   by a clock-cycle bit counter. A good frame updates dataout and pulses
//   done. A low stop bit pulses frame_err instead.
//
// Configuration macro
//   UART_RX_PARITY_EN  - when defined, adds a PARITY state between DATA and
//                        STOP (8E1 framing) and the parity_err output port.
//                        When undefined, the receiver is plain 8N1.
//
// Parameters
//   CLKS_PER_BIT - clk cycles per bit period (even, >= 4)
//   SYNC_STAGES  - number of flops in the rx synchroniser (2..3)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   rx         in   1  serial line, idle high, asynchronous to clk
//   dataout    out  8  last correctly framed byte, held until the next one
//   done       out  1  one-cycle pulse: dataout updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   busy       out  1  receiver is in any state other than IDLE
//   parity_err out  1  (UART_RX_PARITY_EN only) one-cycle pulse alongside
//                      the stop-bit decision when the even parity is wrong
// ============================================================================
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       done,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    // Midpoint of the start bit: counting from the edge that first saw the
    // line low, H cycles later the start bit is half a bit in.
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    // Full bit period: from one midpoint to the next.
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchroniser. Flops reset to 1 so the line reads idle out of reset.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= rx;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
                end
            end
        end
    endgenerate

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_dataout;
    logic            r_done;
    logic            r_frame_err;
    logic            r_par_bad;
    logic            r_parity_err;

    // Decode strobes produced by the output process
    logic            w_at_half;
    logic            w_at_full;
    logic            w_cnt_clr;
    logic            w_sample_data;
    logic            w_sample_par;
    logic            w_enter_data;
    logic            w_stop_good;
    logic            w_stop_bad;

    assign w_at_half = (r_cnt == CNT_HALF);
    assign w_at_full = (r_cnt == CNT_FULL);

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A line that is high again at the start-bit midpoint was
                // only a glitch; drop back without reporting anything.
                if (w_at_half) begin
                    w_state_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_full && (r_bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (w_at_full) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_at_full) begin
                    w_state_next = w_rx_s ? S_IDLE : S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // Hold off re-arming until the line has gone back to idle,
                // otherwise a break would look like an endless run of starts.
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_enter_data  = 1'b0;
        w_stop_good   = 1'b0;
        w_stop_bad    = 1'b0;
        w_cnt_clr     = 1'b1;
        case (r_state)
            S_START: begin
                w_enter_data = w_at_half && !w_rx_s;
                w_cnt_clr    = w_at_half;
            end
            S_DATA: begin
                w_sample_data = w_at_full;
                w_cnt_clr     = w_at_full;
            end
            S_PARITY: begin
                w_sample_par = w_at_full;
                w_cnt_clr    = w_at_full;
            end
            S_STOP: begin
                w_stop_good = w_at_full && w_rx_s;
                w_stop_bad  = w_at_full && !w_rx_s;
                w_cnt_clr   = w_at_full;
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit-period counter. It is cleared on every sample point and whenever
    // the receiver is not timing a bit, so it never runs past CNT_FULL.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Bit index and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_enter_data) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample_data) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Parity check. The mismatch is remembered here and reported alongside
    // the stop-bit decision so that every frame result appears in one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad <= 1'b0;
        end else if (w_enter_data) begin
            r_par_bad <= 1'b0;
        end else if (w_sample_par) begin
            r_par_bad <= (w_rx_s != (^r_shift));
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dataout    <= 8'h00;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_done       <= w_stop_good;
            r_frame_err  <= w_stop_bad;
            r_parity_err <= (w_stop_good || w_stop_bad) && r_par_bad;
            if (w_stop_good) begin
                r_dataout <= r_shift;
            end
        end
    end

    assign dataout   = r_dataout;
    assign done      = r_done;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    // Without the parity stage the checker never fires; keep it tied off.
    logic w_unused_parity;
    assign w_unused_parity = r_parity_err ^ r_par_bad;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ============================================================================
// tb_uart_rx_fsm -- directed testbench for uart_rx_fsm (16 clk/bit, 2 sync)
// Inputs are driven on the falling edge; outputs are observed on the falling
// edge as well, half a period away from the active rising edge.
// ============================================================================
module tb_uart_rx_fsm;

    localparam int N = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif
    localparam int FRAME = LAT + 5;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dataout;
    logic       done;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_fsm #(
        .CLKS_PER_BIT (16),
        .SYNC_STAGES  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .dataout    (dataout),
        .done       (done),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         done_cyc[$];
    logic [7:0] done_data[$];
    int         ferr_cyc[$];
    logic       par_q[$];
    int         both_hi = 0;

    // Event log of output pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_data.push_back(dataout);
`ifdef UART_RX_PARITY_EN
            par_q.push_back(parity_err);
`endif
        end
        if (frame_err === 1'b1) ferr_cyc.push_back(cyc);
        if (done === 1'b1 && frame_err === 1'b1) both_hi = both_hi + 1;
    end

    task automatic clear_log();
        done_cyc.delete();
        done_data.delete();
        ferr_cyc.delete();
        par_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`else
        if (par_b === 1'bz) rx = 1'b1;
`endif
        drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        rx    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (dataout !== 8'h00) begin n_miss++; $display("FAIL reset_dataout: got %h expected 00", dataout); end
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset: dataout=%h done=%b frame_err=%b busy=%b", dataout, done, frame_err, busy);
    endtask

    task automatic test_single();
        int t0;
        logic [7:0] d;
        d = 8'hA5;
        clear_log();
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL single_busy_mid: got %b expected 1", busy); end
        for (int i = 4; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (done_cyc.size() !== 1) begin n_miss++; $display("FAIL single_done_count: got %0d expected 1", done_cyc.size()); end
        if (done_cyc.size() > 0) begin
            n_vec++; if (done_cyc[0] - t0 !== LAT) begin n_miss++; $display("FAIL single_latency: got %0d expected %0d", done_cyc[0] - t0, LAT); end
            n_vec++; if (done_data[0] !== 8'hA5) begin n_miss++; $display("FAIL single_data: got %h expected a5", done_data[0]); end
        end
        n_vec++; if (ferr_cyc.size() !== 0) begin n_miss++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cyc.size()); end
        $display("single 0xA5: dones=%0d dataout=%h", done_cyc.size(), dataout);
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (done_cyc.size() !== 2) begin n_miss++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc.size()); end
        if (done_cyc.size() >= 2) begin
            n_vec++; if (done_data[0] !== 8'h00) begin n_miss++; $display("FAIL b2b_data0: got %h expected 00", done_data[0]); end
            n_vec++; if (done_data[1] !== 8'hFF) begin n_miss++; $display("FAIL b2b_data1: got %h expected ff", done_data[1]); end
            n_vec++; if (done_cyc[1] - done_cyc[0] !== FRAME) begin n_miss++; $display("FAIL b2b_gap: got %0d expected %0d", done_cyc[1] - done_cyc[0], FRAME); end
        end
        $display("back_to_back 0x00,0xFF: dones=%0d dataout=%h", done_cyc.size(), dataout);
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (done_cyc.size() !== 0) begin n_miss++; $display("FAIL glitch_done: got %0d expected 0", done_cyc.size()); end
        n_vec++; if (ferr_cyc.size() !== 0) begin n_miss++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cyc.size()); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        n_vec++; if (dataout !== 8'hFF) begin n_miss++; $display("FAIL glitch_dataout: got %h expected ff", dataout); end
        $display("glitch: busy=%b dataout=%h", busy, dataout);
    endtask

    task automatic test_framing();
        int t0;
        clear_log();
        t0 = cyc;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        n_vec++; if (ferr_cyc.size() !== 1) begin n_miss++; $display("FAIL framing_ferr_count: got %0d expected 1", ferr_cyc.size()); end
        if (ferr_cyc.size() > 0) begin
            n_vec++; if (ferr_cyc[0] - t0 !== LAT) begin n_miss++; $display("FAIL framing_latency: got %0d expected %0d", ferr_cyc[0] - t0, LAT); end
        end
        n_vec++; if (done_cyc.size() !== 0) begin n_miss++; $display("FAIL framing_done: got %0d expected 0", done_cyc.size()); end
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL framing_busy_held: got %b expected 1", busy); end
        n_vec++; if (dataout !== 8'hFF) begin n_miss++; $display("FAIL framing_dataout: got %h expected ff", dataout); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL framing_busy_release: got %b expected 0", busy); end
        clear_log();
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (dataout !== 8'h81 || done_cyc.size() !== 1) begin n_miss++; $display("FAIL framing_recover: got %h/%0d expected 81/1", dataout, done_cyc.size()); end
        $display("framing 0x3C: ferr=%0d dataout=%h", ferr_cyc.size(), dataout);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h5A;
        clear_log();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        n_vec++; if (dataout !== 8'h00) begin n_miss++; $display("FAIL rstmid_dataout: got %h expected 00", dataout); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (done_cyc.size() !== 0 || ferr_cyc.size() !== 0) begin n_miss++; $display("FAIL rstmid_pulses: got %0d/%0d expected 0/0", done_cyc.size(), ferr_cyc.size()); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        send_frame(8'hC3, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (dataout !== 8'hC3 || done_cyc.size() !== 1) begin n_miss++; $display("FAIL rstmid_next: got %h/%0d expected c3/1", dataout, done_cyc.size()); end
        $display("reset_mid 0x5A then 0xC3: dataout=%h", dataout);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_log();
        send_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        n_vec++; if (done_cyc.size() !== 2) begin n_miss++; $display("FAIL parity_done_count: got %0d expected 2", done_cyc.size()); end
        if (par_q.size() >= 2) begin
            n_vec++; if (par_q[0] !== 1'b1) begin n_miss++; $display("FAIL parity_bad: got %b expected 1", par_q[0]); end
            n_vec++; if (par_q[1] !== 1'b0) begin n_miss++; $display("FAIL parity_good: got %b expected 0", par_q[1]); end
            n_vec++; if (done_data[1] !== 8'h07) begin n_miss++; $display("FAIL parity_data: got %h expected 07", done_data[1]); end
        end
        $display("parity 0x07: dones=%0d dataout=%h", done_cyc.size(), dataout);
    endtask
`endif

    task automatic test_exclusive();
        n_vec++; if (both_hi !== 0) begin n_miss++; $display("FAIL done_ferr_overlap: got %0d expected 0", both_hi); end
        $display("exclusive: overlap cycles=%0d", both_hi);
    endtask

    initial begin
        rst_n = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
